// File: rtl/branch_compare_pipe.sv
// Pipelined branch-resolution comparator with valid/ready handshake, flush,
// mispredict detection and a saturating count of retired taken branches.
module branch_compare_pipe #(
  parameter int WIDTH     = 16,
  parameter int LATENCY   = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     FirstInput,
  input  logic [WIDTH-1:0]     SecondInput,
  input  logic [2:0]           OPCode,
  input  logic                 PredictTaken,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic                 Flush,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 BranchComparison,
  output logic                 Mispredict,
  output logic [CNT_WIDTH-1:0] TakenCount
);

  localparam logic [2:0] OP_BNE  = 3'd0;
  localparam logic [2:0] OP_BGE  = 3'd1;
  localparam logic [2:0] OP_BLTU = 3'd2;
  localparam logic [2:0] OP_BGEU = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_BLT  = 3'd5;

  function automatic logic resolve(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic [2:0]       op);
    logic eq, ltu, lts, res;
    eq  = (a == b);
    ltu = (a < b);
    lts = ($signed(a) < $signed(b));
    case (op)
      OP_BNE:  res = !eq;
      OP_BGE:  res = !lts;
      OP_BLTU: res = ltu;
      OP_BGEU: res = !ltu;
      OP_BEQ:  res = eq;
      OP_BLT:  res = lts;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  logic out_advance;
  logic first_advance;
  logic accept;
  logic retire;

  assign out_advance = !OutValid || OutReady;
  // Flush forces ready so upstream never stalls on a cycle that discards everything.
  assign InReady     = first_advance || Flush;
  assign accept      = InValid && first_advance && !Flush;
  assign retire      = OutValid && OutReady && !Flush;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign first_advance = out_advance;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          OutValid         <= 1'b0;
          BranchComparison <= 1'b0;
          Mispredict       <= 1'b0;
        end else if (Flush) begin
          OutValid <= 1'b0;
        end else if (out_advance) begin
          OutValid <= accept;
          if (accept) begin
            BranchComparison <= resolve(FirstInput, SecondInput, OPCode);
            Mispredict       <= resolve(FirstInput, SecondInput, OPCode) ^ PredictTaken;
          end
        end
      end
    end else if (LATENCY == 2) begin : g_lat2
      logic             s1_valid;
      logic [WIDTH-1:0] s1_a;
      logic [WIDTH-1:0] s1_b;
      logic [2:0]       s1_op;
      logic             s1_pred;
      logic             s1_taken;

      assign first_advance = !s1_valid || out_advance;
      assign s1_taken      = resolve(s1_a, s1_b, s1_op);

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          s1_valid <= 1'b0;
          s1_a     <= '0;
          s1_b     <= '0;
          s1_op    <= '0;
          s1_pred  <= 1'b0;
        end else if (Flush) begin
          s1_valid <= 1'b0;
        end else if (first_advance) begin
          s1_valid <= accept;
          if (accept) begin
            s1_a    <= FirstInput;
            s1_b    <= SecondInput;
            s1_op   <= OPCode;
            s1_pred <= PredictTaken;
          end
        end
      end

      // Result registers only load with real data so a stalled result stays stable.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          OutValid         <= 1'b0;
          BranchComparison <= 1'b0;
          Mispredict       <= 1'b0;
        end else if (Flush) begin
          OutValid <= 1'b0;
        end else if (out_advance) begin
          OutValid <= s1_valid;
          if (s1_valid) begin
            BranchComparison <= s1_taken;
            Mispredict       <= s1_taken ^ s1_pred;
          end
        end
      end
    end else begin : g_bad_latency
      $error("branch_compare_pipe: LATENCY must be 1 or 2");
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      TakenCount <= '0;
    end else if (retire && BranchComparison && (TakenCount != {CNT_WIDTH{1'b1}})) begin
      TakenCount <= TakenCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Scoreboard bench for branch_compare_pipe: three instances (LATENCY 1, LATENCY 2,
// 2-bit counter) share stimulus, one is selected at a time for handshake and checking.
module tb_branch_compare_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic branch;
    logic mis;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] first_in, second_in;
  logic [2:0]   op;
  logic         pred, in_valid, flush, out_ready;
  int           sel;

  logic [2:0]   in_ready_v, out_valid_v, branch_v, mis_v;
  logic [7:0]   cnt_a, cnt_b;
  logic [1:0]   cnt_c;
  logic         in_ready_m, ov_m, br_m, mis_m;
  logic [7:0]   cnt_m;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  exp_t sb[$];
  int   exp_count[3];
  bit   count_pending;
  logic prev_stall, prev_br, prev_mis;
  exp_t mon_e;

  always #5 clk = ~clk;

  branch_compare_pipe #(.WIDTH(W), .LATENCY(1), .CNT_WIDTH(8)) dut_a (
    .CLK(clk), .RST(rst), .FirstInput(first_in), .SecondInput(second_in), .OPCode(op),
    .PredictTaken(pred), .InValid(in_valid && sel == 0), .InReady(in_ready_v[0]),
    .Flush(flush), .OutValid(out_valid_v[0]), .OutReady(out_ready),
    .BranchComparison(branch_v[0]), .Mispredict(mis_v[0]), .TakenCount(cnt_a));

  branch_compare_pipe #(.WIDTH(W), .LATENCY(2), .CNT_WIDTH(8)) dut_b (
    .CLK(clk), .RST(rst), .FirstInput(first_in), .SecondInput(second_in), .OPCode(op),
    .PredictTaken(pred), .InValid(in_valid && sel == 1), .InReady(in_ready_v[1]),
    .Flush(flush), .OutValid(out_valid_v[1]), .OutReady(out_ready),
    .BranchComparison(branch_v[1]), .Mispredict(mis_v[1]), .TakenCount(cnt_b));

  branch_compare_pipe #(.WIDTH(W), .LATENCY(1), .CNT_WIDTH(2)) dut_c (
    .CLK(clk), .RST(rst), .FirstInput(first_in), .SecondInput(second_in), .OPCode(op),
    .PredictTaken(pred), .InValid(in_valid && sel == 2), .InReady(in_ready_v[2]),
    .Flush(flush), .OutValid(out_valid_v[2]), .OutReady(out_ready),
    .BranchComparison(branch_v[2]), .Mispredict(mis_v[2]), .TakenCount(cnt_c));

  always_comb begin
    in_ready_m = in_ready_v[0];
    ov_m       = out_valid_v[0];
    br_m       = branch_v[0];
    mis_m      = mis_v[0];
    cnt_m      = cnt_a;
    case (sel)
      1: begin
        in_ready_m = in_ready_v[1]; ov_m = out_valid_v[1];
        br_m = branch_v[1]; mis_m = mis_v[1]; cnt_m = cnt_b;
      end
      2: begin
        in_ready_m = in_ready_v[2]; ov_m = out_valid_v[2];
        br_m = branch_v[2]; mis_m = mis_v[2]; cnt_m = {6'b0, cnt_c};
      end
      default: ;
    endcase
  end

  function automatic int cnt_max(input int s);
    return (s == 2) ? 3 : 255;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every retire, checks stall stability and the counter.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall    = 1'b0;
      count_pending = 1'b0;
    end else begin
      if (count_pending) begin
        check_output("taken_count", {24'b0, cnt_m}, exp_count[sel]);
        count_pending = 1'b0;
      end
      if (ov_m && prev_stall) begin
        check_output("stall_branch", {31'b0, br_m}, {31'b0, prev_br});
        check_output("stall_mispredict", {31'b0, mis_m}, {31'b0, prev_mis});
      end
      if (ov_m && out_ready && !flush) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_output: got OutValid=1 expected no pending result (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check_output("branch", {31'b0, br_m}, {31'b0, mon_e.branch});
          check_output("mispredict", {31'b0, mis_m}, {31'b0, mon_e.mis});
          if (mon_e.branch && exp_count[sel] < cnt_max(sel)) exp_count[sel]++;
          count_pending = 1'b1;
        end
      end
      prev_stall = ov_m && !out_ready;
      prev_br    = br_m;
      prev_mis   = mis_m;
    end
  end

  // Issues one transaction, pushing its expectation at the accepting edge.
  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                                input logic p, input logic exp_br);
    logic rdy;
    bit   accepted;
    first_in  = a;
    second_in = b;
    op        = o;
    pred      = p;
    in_valid  = 1'b1;
    accepted  = 0;
    for (int i = 0; i < 30 && !accepted; i++) begin
      @(negedge clk);
      rdy = in_ready_m;
      @(posedge clk);
      if (rdy) begin
        accepted = 1;
        sb.push_back('{branch: exp_br, mis: exp_br ^ p});
      end
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) check_output("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_output("drain", sb.size(), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq[5];
    seq = '{1, 2, 3, 3, 3};
    rst = 1'b1; sel = 0; first_in = '0; second_in = '0; op = '0; pred = 1'b0;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    exp_count[0] = 0; exp_count[1] = 0; exp_count[2] = 0;

    repeat (2) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_output("reset_outvalid", {31'b0, ov_m}, 32'd0);
      check_output("reset_count", {24'b0, cnt_m}, 32'd0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 check_output("ready_after_release", {31'b0, in_ready_m}, 32'd1);
    end

    // LATENCY=1: equality, signedness, mispredict
    sel = 0;
    @(posedge clk); #1;
    apply_stimulus(16'd16, 16'd16, 3'd4, 1'b0, 1'b1);
    check_output("lat1_valid_next", {31'b0, ov_m}, 32'd1);
    apply_stimulus(16'd16, 16'd4, 3'd4, 1'b0, 1'b0);
    apply_stimulus(16'hFFFF, 16'h0001, 3'd5, 1'b1, 1'b1);
    apply_stimulus(16'hFFFF, 16'h0001, 3'd2, 1'b1, 1'b0);
    apply_stimulus(16'h8000, 16'h7FFF, 3'd1, 1'b0, 1'b0);
    apply_stimulus(16'h8000, 16'h7FFF, 3'd3, 1'b0, 1'b1);
    apply_stimulus(16'd5, 16'd5, 3'd0, 1'b1, 1'b0);
    apply_stimulus(16'd9, 16'd2, 3'd7, 1'b1, 1'b1);
    wait_drain();
    check_output("lat1_count", {24'b0, cnt_m}, 32'd4);

    // LATENCY=2 backpressure
    sel = 1;
    out_ready = 1'b0;
    apply_stimulus(16'd1, 16'd2, 3'd6, 1'b1, 1'b1);
    check_output("lat2_not_yet", {31'b0, ov_m}, 32'd0);
    apply_stimulus(16'd3, 16'd4, 3'd6, 1'b0, 1'b1);
    check_output("lat2_valid", {31'b0, ov_m}, 32'd1);
    check_output("lat2_ready_low", {31'b0, in_ready_m}, 32'd0);
    check_output("lat2_branch_held", {31'b0, br_m}, 32'd1);
    @(posedge clk); #1;
    check_output("lat2_still_valid", {31'b0, ov_m}, 32'd1);
    fork
      begin
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    apply_stimulus(16'd5, 16'd6, 3'd6, 1'b1, 1'b1);
    apply_stimulus(16'd7, 16'd8, 3'd6, 1'b0, 1'b1);
    wait_drain();
    check_output("lat2_count", {24'b0, cnt_m}, 32'd4);

    // Saturation with a 2-bit counter
    sel = 2;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(16'd0, 16'd0, 3'd6, 1'b1, 1'b1);
      @(posedge clk); #1;
      check_output("sat_count", {24'b0, cnt_m}, seq[k]);
    end
    wait_drain();

    // Flush with two in flight
    sel = 1;
    out_ready = 1'b0;
    apply_stimulus(16'd3, 16'd3, 3'd4, 1'b1, 1'b1);
    apply_stimulus(16'd3, 16'd3, 3'd4, 1'b0, 1'b1);
    flush = 1'b1;
    in_valid = 1'b1;
    first_in = 16'd7; second_in = 16'd7; op = 3'd4;
    #1 check_output("flush_ready", {31'b0, in_ready_m}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check_output("flush_outvalid", {31'b0, ov_m}, 32'd0);
    check_output("flush_count", {24'b0, cnt_m}, 32'd4);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_output("flush_no_capture", {31'b0, ov_m}, 32'd0);
    apply_stimulus(16'd1, 16'd2, 3'd4, 1'b0, 1'b0);
    wait_drain();
    check_output("post_flush_count", {24'b0, cnt_m}, 32'd4);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    apply_stimulus(16'd1, 16'd1, 3'd6, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_output("pre_reset_valid", {31'b0, ov_m}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check_output("async_outvalid", {31'b0, ov_m}, 32'd0);
    check_output("async_branch", {31'b0, br_m}, 32'd0);
    check_output("async_mispredict", {31'b0, mis_m}, 32'd0);
    check_output("async_count_b", {24'b0, cnt_b}, 32'd0);
    check_output("async_count_a", {24'b0, cnt_a}, 32'd0);
    sb.delete();
    exp_count[0] = 0; exp_count[1] = 0; exp_count[2] = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_output("ready_after_reset", {31'b0, in_ready_m}, 32'd1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
